boc_epl_corr: RTL and testbench
===============================

BOC_EPL_CORR -- requirements
Module: boc_epl_corr

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 4, signed I/Q sample width.
REQ-002 Parameter ACC_WIDTH, default 20, signed accumulator and output width.
REQ-003 Parameter SPACING, default 2, early-prompt and prompt-late spacing in clocks, range 1..8.
REQ-004 rx_clk  input  1  sole clock, rising edge.
REQ-005 rx_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rx_corr_en  input  1  channel enable, level.
REQ-007 rx_sample_valid  input  1  I/Q sample qualifier.
REQ-008 rx_sample_i, rx_sample_q  input  SAMPLE_WIDTH  signed baseband samples.
REQ-009 rx_loc_boc  input  1  local BOC-modulated code from the PRN generator, one chip-state per clock.
REQ-010 rx_prn_sop, rx_prn_eop  input  1  code-period start/end pulses, aligned with rx_loc_boc.
REQ-011 tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql  output  ACC_WIDTH  dumped early/prompt/late I/Q sums.
REQ-012 tx_dump_valid  output  1  one-cycle pulse, dump outputs updated.
REQ-013 tx_epoch_cnt  output  8  dump counter.
REQ-014 tx_eop_err  output  1  period ended without an eop.
REQ-015 tx_sat  output  1  saturation occurred in dumped period.

Function
REQ-016 Delay line SHALL shift every clock: stage 0 registers {rx_loc_boc, rx_prn_sop, rx_prn_eop}; depth 2*SPACING+1 stages.
REQ-017 Early code SHALL be stage 0, prompt stage SPACING, late stage 2*SPACING; sop/eop SHALL be taken from prompt stage (psop, peop).
REQ-018 Code bit 0 SHALL map to +1, bit 1 to -1; product = sample or its two's-complement negation, sign-extended to ACC_WIDTH.
REQ-019 State machine SHALL have IDLE, WAIT_SOP, ACCUM; rx_corr_en low SHALL force IDLE from any state within one clock and clear accumulators, eop flag, sat flag.
REQ-020 IDLE -> WAIT_SOP when rx_corr_en high; WAIT_SOP -> ACCUM on psop; psop cycle loads accumulators with current products (zero if rx_sample_valid low).
REQ-021 In ACCUM each rx_sample_valid cycle SHALL add products to all six accumulators; invalid cycles hold.
REQ-022 On psop in ACCUM: dump registers SHALL take accumulator values excluding the psop-cycle sample; accumulators SHALL load the psop-cycle products; tx_dump_valid SHALL pulse on the next clock, with dump outputs valid the same cycle.
REQ-023 eop flag SHALL set on peop in ACCUM, clear at dump; peop coincident with psop SHALL count toward the ending period.
REQ-024 tx_eop_err SHALL equal the inverted eop flag at dump, held until next dump.
REQ-025 tx_epoch_cnt SHALL increment per dump, wrapping 255 -> 0.
REQ-026 Dump outputs, tx_eop_err, tx_sat SHALL hold between dumps and across rx_corr_en deassertion.

Reset
REQ-027 rx_rst_n low SHALL asynchronously clear all delay stages, accumulators, dump outputs, tx_epoch_cnt, flags, tx_dump_valid, and set state IDLE.
REQ-028 Reset mid-period SHALL discard the partial sum; first dump after release SHALL require two psops.

Configuration
REQ-029 Macro BOC_EPL_CORR_SAT_EN defined: accumulators SHALL clamp to +(2^(ACC_WIDTH-1)-1) / -(2^(ACC_WIDTH-1)); clamping sets a sticky flag copied to tx_sat at dump, then cleared.
REQ-030 Macro undefined: accumulators SHALL wrap two's complement; tx_sat SHALL be constant 0.

Verification
REQ-031 SPACING=2, I=+3, Q=-1 every cycle, code constant 0, psop every 100 clocks with peop at clock 99 -> tx_ip=300, tx_qp=-100, tx_ie=tx_il=300, tx_eop_err=0.
REQ-032 Code alternating 0/1 each clock, I=+5 -> tx_ip magnitude <=5, tx_ie = -tx_ip (odd spacing 1) for SPACING=1.
REQ-033 Period with peop suppressed -> tx_eop_err=1 at that dump only; next normal period -> 0.
REQ-034 I=+7, code 0, period 2^18 clocks, ACC_WIDTH=20 -> with macro tx_ip=524287, tx_sat=1; without macro wrapped value, tx_sat=0.
REQ-035 rx_rst_n pulsed low mid-ACCUM -> all outputs 0 immediately; 256 dumps afterwards -> tx_epoch_cnt wraps to 0.
REQ-036 rx_corr_en dropped then raised 10 clocks before psop -> no dump at that psop; dump at the following psop.

Source files
------------

// File: rtl/boc_epl_corr_if.sv
// Correlator channel bus: sample/code inputs toward the correlator, dump results back.
// master = sample/code source, slave = boc_epl_corr.
interface boc_epl_corr_if #(
    parameter int SAMPLE_WIDTH = 4,
    parameter int ACC_WIDTH    = 20
);
    logic                           rx_corr_en;
    logic                           rx_sample_valid;
    logic signed [SAMPLE_WIDTH-1:0] rx_sample_i;
    logic signed [SAMPLE_WIDTH-1:0] rx_sample_q;
    logic                           rx_loc_boc;
    logic                           rx_prn_sop;
    logic                           rx_prn_eop;
    logic signed [ACC_WIDTH-1:0]    tx_ie;
    logic signed [ACC_WIDTH-1:0]    tx_qe;
    logic signed [ACC_WIDTH-1:0]    tx_ip;
    logic signed [ACC_WIDTH-1:0]    tx_qp;
    logic signed [ACC_WIDTH-1:0]    tx_il;
    logic signed [ACC_WIDTH-1:0]    tx_ql;
    logic                           tx_dump_valid;
    logic [7:0]                     tx_epoch_cnt;
    logic                           tx_eop_err;
    logic                           tx_sat;

    modport master (
        output rx_corr_en, rx_sample_valid, rx_sample_i, rx_sample_q,
               rx_loc_boc, rx_prn_sop, rx_prn_eop,
        input  tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql,
               tx_dump_valid, tx_epoch_cnt, tx_eop_err, tx_sat
    );

    modport slave (
        input  rx_corr_en, rx_sample_valid, rx_sample_i, rx_sample_q,
               rx_loc_boc, rx_prn_sop, rx_prn_eop,
        output tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql,
               tx_dump_valid, tx_epoch_cnt, tx_eop_err, tx_sat
    );
endinterface

// File: rtl/boc_epl_corr.sv
// Early/prompt/late BOC correlator: despreads I/Q against a delayed local code and dumps per code period.
// Define BOC_EPL_CORR_SAT_EN for saturating accumulators with tx_sat reporting; default wraps.
module boc_epl_corr #(
    parameter int SAMPLE_WIDTH = 4,
    parameter int ACC_WIDTH    = 20,
    parameter int SPACING      = 2
) (
    input  logic          rx_clk,
    input  logic          rx_rst_n,
    boc_epl_corr_if.slave bus
);
    localparam int DEPTH = 2 * SPACING + 1;
    localparam int NACC  = 6;
    localparam int IE = 0, QE = 1, IP = 2, QP = 3, IL = 4, QL = 5;

    typedef enum logic [1:0] {IDLE, WAIT_SOP, ACCUM} state_t;

    state_t                      state;
    logic [2:0]                  dline [DEPTH];   // {code, sop, eop}
    logic                        code_e, code_p, code_l, psop, peop;
    logic signed [ACC_WIDTH-1:0] ext_i, ext_q;
    logic signed [ACC_WIDTH-1:0] prod    [NACC];
    logic signed [ACC_WIDTH-1:0] acc     [NACC];
    logic signed [ACC_WIDTH-1:0] acc_nxt [NACC];
    logic signed [ACC_WIDTH-1:0] dump    [NACC];
    logic                        eop_flag, eop_err, dump_valid;
    logic [7:0]                  epoch_cnt;

    function automatic logic signed [ACC_WIDTH-1:0] despread(
        input logic signed [ACC_WIDTH-1:0] s,
        input logic                        code,
        input logic                        valid
    );
        if (!valid) return '0;
        return code ? -s : s;
    endfunction

    assign code_e = dline[0][2];
    assign code_p = dline[SPACING][2];
    assign code_l = dline[2*SPACING][2];
    assign psop   = dline[SPACING][1];
    assign peop   = dline[SPACING][0];

    always_comb begin
        ext_i = {{(ACC_WIDTH-SAMPLE_WIDTH){bus.rx_sample_i[SAMPLE_WIDTH-1]}}, bus.rx_sample_i};
        ext_q = {{(ACC_WIDTH-SAMPLE_WIDTH){bus.rx_sample_q[SAMPLE_WIDTH-1]}}, bus.rx_sample_q};
        prod[IE] = despread(ext_i, code_e, bus.rx_sample_valid);
        prod[QE] = despread(ext_q, code_e, bus.rx_sample_valid);
        prod[IP] = despread(ext_i, code_p, bus.rx_sample_valid);
        prod[QP] = despread(ext_q, code_p, bus.rx_sample_valid);
        prod[IL] = despread(ext_i, code_l, bus.rx_sample_valid);
        prod[QL] = despread(ext_q, code_l, bus.rx_sample_valid);
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state      <= IDLE;
            dline      <= '{default: '0};
            acc        <= '{default: '0};
            dump       <= '{default: '0};
            eop_flag   <= 1'b0;
            eop_err    <= 1'b0;
            dump_valid <= 1'b0;
            epoch_cnt  <= '0;
        end else begin
            dline[0] <= {bus.rx_loc_boc, bus.rx_prn_sop, bus.rx_prn_eop};
            for (int unsigned k = 1; k < DEPTH; k++) dline[k] <= dline[k-1];
            dump_valid <= 1'b0;
            if (!bus.rx_corr_en) begin
                state    <= IDLE;
                acc      <= '{default: '0};
                eop_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_SOP;
                    WAIT_SOP: if (psop) begin
                        state    <= ACCUM;
                        acc      <= prod;
                        eop_flag <= 1'b0;
                    end
                    ACCUM: if (psop) begin
                        // Dump excludes the psop sample, which opens the next period.
                        dump       <= acc;
                        acc        <= prod;
                        eop_err    <= ~(eop_flag | peop);
                        eop_flag   <= 1'b0;
                        dump_valid <= 1'b1;
                        epoch_cnt  <= epoch_cnt + 8'd1;
                    end else begin
                        if (peop) eop_flag <= 1'b1;
                        if (bus.rx_sample_valid) acc <= acc_nxt;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BOC_EPL_CORR_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH:0] sum_ext [NACC];
    logic [NACC-1:0]           ovf;
    logic                      sat_flag, sat_q;

    always_comb begin
        for (int unsigned k = 0; k < NACC; k++) begin
            sum_ext[k] = {acc[k][ACC_WIDTH-1], acc[k]} + {prod[k][ACC_WIDTH-1], prod[k]};
            ovf[k]     = sum_ext[k][ACC_WIDTH] ^ sum_ext[k][ACC_WIDTH-1];
            acc_nxt[k] = ovf[k] ? (sum_ext[k][ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                : sum_ext[k][ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            sat_flag <= 1'b0;
            sat_q    <= 1'b0;
        end else if (!bus.rx_corr_en) begin
            sat_flag <= 1'b0;
        end else if (state == ACCUM) begin
            if (psop) begin
                sat_q    <= sat_flag;
                sat_flag <= 1'b0;
            end else if (bus.rx_sample_valid && |ovf) begin
                sat_flag <= 1'b1;
            end
        end
    end

    assign bus.tx_sat = sat_q;
`else
    always_comb begin
        for (int unsigned k = 0; k < NACC; k++) acc_nxt[k] = acc[k] + prod[k];
    end

    assign bus.tx_sat = 1'b0;
`endif

    assign bus.tx_ie         = dump[IE];
    assign bus.tx_qe         = dump[QE];
    assign bus.tx_ip         = dump[IP];
    assign bus.tx_qp         = dump[QP];
    assign bus.tx_il         = dump[IL];
    assign bus.tx_ql         = dump[QL];
    assign bus.tx_dump_valid = dump_valid;
    assign bus.tx_epoch_cnt  = epoch_cnt;
    assign bus.tx_eop_err    = eop_err;
endmodule

// File: tb/tb_boc_epl_corr.sv
// Randomized bench for boc_epl_corr against a cycle-level behavioural model of the dump results.
// Build with BOC_EPL_CORR_SAT_EN to check the saturating variant.
module tb_boc_epl_corr;
    localparam int SW = 4;
    localparam int AW = 12;
    localparam int SP = 2;
    localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (AW - 1));

    logic rx_clk   = 1'b0;
    logic rx_rst_n = 1'b1;
    always #5 rx_clk = ~rx_clk;

    boc_epl_corr_if #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW)) bus ();

    boc_epl_corr #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW), .SPACING(SP)) dut (
        .rx_clk   (rx_clk),
        .rx_rst_n (rx_rst_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: code history, period sums as unbounded integers, dump expectations.
    bit     hc[$], hs[$], he[$];
    int     en_run;
    bit     locked, eop_seen, sat_seen;
    longint acc[6];
    longint exp_dump[6];
    bit     exp_dv, exp_err, exp_sat;
    int     exp_epoch;

    function automatic longint wrapv(input longint v);
        longint m = longint'(1) << AW;
        longint r = v % m;
        if (r < 0) r += m;
        if (r > MAXV) r -= m;
        return r;
    endfunction

    function automatic int rsamp();
        return int'($urandom_range(0, (1 << SW) - 1)) - (1 << (SW - 1));
    endfunction

    task automatic model_reset();
        hc.delete(); hs.delete(); he.delete();
        for (int k = 0; k < 2 * SP + 1; k++) begin
            hc.push_back(1'b0); hs.push_back(1'b0); he.push_back(1'b0);
        end
        en_run = 0; locked = 0; eop_seen = 0; sat_seen = 0;
        exp_dv = 0; exp_err = 0; exp_sat = 0; exp_epoch = 0;
        for (int k = 0; k < 6; k++) begin acc[k] = 0; exp_dump[k] = 0; end
    endtask

    task automatic model_step(input bit en, input bit valid, input int si, input int sq,
                              input bit code, input bit sop, input bit eop);
        bit     c[3];
        longint p[6];
        bit     psop, peop;
        c[0] = hc[0]; c[1] = hc[SP]; c[2] = hc[2 * SP];
        psop = hs[SP]; peop = he[SP];
        hc.push_front(code); void'(hc.pop_back());
        hs.push_front(sop);  void'(hs.pop_back());
        he.push_front(eop);  void'(he.pop_back());
        for (int k = 0; k < 6; k++) begin
            longint s = (k % 2 == 0) ? longint'(si) : longint'(sq);
            p[k] = !valid ? 0 : (c[k / 2] ? -s : s);
        end
        exp_dv = 0;
        if (!en) begin
            en_run = 0; locked = 0; eop_seen = 0; sat_seen = 0;
            for (int k = 0; k < 6; k++) acc[k] = 0;
        end else if (en_run == 0) begin
            en_run = 1;
        end else if (!locked) begin
            if (psop) begin locked = 1; acc = p; end
        end else if (psop) begin
            for (int k = 0; k < 6; k++) exp_dump[k] = wrapv(acc[k]);
            exp_err = !(eop_seen || peop);
`ifdef BOC_EPL_CORR_SAT_EN
            exp_sat = sat_seen;
`endif
            exp_epoch = (exp_epoch + 1) % 256;
            exp_dv = 1;
            acc = p; eop_seen = 0; sat_seen = 0;
        end else begin
            if (peop) eop_seen = 1;
            for (int k = 0; k < 6; k++) begin
                longint s = acc[k] + p[k];
`ifdef BOC_EPL_CORR_SAT_EN
                if (s > MAXV) begin s = MAXV; sat_seen = 1; end
                else if (s < MINV) begin s = MINV; sat_seen = 1; end
`endif
                acc[k] = s;
            end
        end
    endtask

    task automatic compare_outputs();
        check("dump_valid", longint'(bus.tx_dump_valid), longint'(exp_dv));
        check("epoch_cnt", longint'(bus.tx_epoch_cnt), longint'(exp_epoch));
        check("eop_err", longint'(bus.tx_eop_err), longint'(exp_err));
        check("sat", longint'(bus.tx_sat), longint'(exp_sat));
        check("ie", longint'(bus.tx_ie), exp_dump[0]);
        check("qe", longint'(bus.tx_qe), exp_dump[1]);
        check("ip", longint'(bus.tx_ip), exp_dump[2]);
        check("qp", longint'(bus.tx_qp), exp_dump[3]);
        check("il", longint'(bus.tx_il), exp_dump[4]);
        check("ql", longint'(bus.tx_ql), exp_dump[5]);
    endtask

    task automatic drive(input bit en, input bit valid, input int si, input int sq,
                         input bit code, input bit sop, input bit eop);
        bus.rx_corr_en      = en;
        bus.rx_sample_valid = valid;
        bus.rx_sample_i     = SW'(si);
        bus.rx_sample_q     = SW'(sq);
        bus.rx_loc_boc      = code;
        bus.rx_prn_sop      = sop;
        bus.rx_prn_eop      = eop;
    endtask

    task automatic cyc(input bit en, input bit valid, input int si, input int sq,
                       input bit code, input bit sop, input bit eop);
        @(negedge rx_clk);
        compare_outputs();
        drive(en, valid, si, sq, code, sop, eop);
        if (rx_rst_n) model_step(en, valid, si, sq, code, sop, eop);
    endtask

    task automatic do_reset();
        @(negedge rx_clk);
        rx_rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        compare_outputs();
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        rx_rst_n = 1'b1;
        model_step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // kind: 0 constant I=3/Q=-1 code 0, 1 alternating code I=5, 2 max-magnitude code 0, else random
    task automatic run_period(input int len, input int kind, input bit eop_on,
                              input int off_at, input int off_len);
        for (int t = 0; t < len; t++) begin
            bit en = !(t >= off_at && t < off_at + off_len);
            bit v  = 1'b1;
            bit c  = 1'b0;
            int si = 0;
            int sq = 0;
            case (kind)
                0: begin si = 3; sq = -1; end
                1: begin si = 5; sq = -2; c = t[0]; end
                2: begin si = 7; sq = -8; end
                default: begin
                    v  = ($urandom_range(0, 3) != 0);
                    si = rsamp();
                    sq = rsamp();
                    c  = 1'($urandom_range(0, 1));
                end
            endcase
            cyc(en, v, si, sq, c, t == 0, eop_on && t == len - 1);
        end
    endtask

    initial begin
        int len;
        int off_at;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        do_reset();

        repeat (4) run_period(100, 0, 1'b1, 0, 0);
        repeat (4) run_period(40, 1, 1'b1, 0, 0);

        run_period(30, 3, 1'b1, 0, 0);
        run_period(30, 3, 1'b0, 0, 0);
        run_period(30, 3, 1'b1, 0, 0);
        run_period(30, 3, 1'b1, 0, 0);

        repeat (3) run_period(400, 2, 1'b1, 0, 0);

        run_period(50, 3, 1'b1, 35, 5);
        run_period(50, 3, 1'b1, 0, 0);
        run_period(50, 3, 1'b1, 0, 0);

        repeat (40) begin
            len    = int'($urandom_range(8, 60));
            off_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : len;
            run_period(len, 3, $urandom_range(0, 6) != 0, off_at, int'($urandom_range(1, 12)));
        end

        run_period(40, 3, 1'b1, 0, 0);
        run_period(25, 3, 1'b1, 0, 0);
        do_reset();

        repeat (262) run_period(4, 3, 1'b1, 0, 0);
        run_period(10, 3, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end
endmodule
